// File: rtl/overlay_rom_sched_if.sv
// overlay_rom_sched_if: scan coordinates, window config, ROM port and pixel result of overlay_rom_sched
interface overlay_rom_sched_if #(
    parameter int ADDR_W  = 13,
    parameter int COORD_W = 11
);
    logic [COORD_W-1:0] col_addr_sig;
    logic [COORD_W-1:0] row_addr_sig;
    logic               cfg_we;
    logic [1:0]         cfg_sel;
    logic [COORD_W-1:0] cfg_x;
    logic [COORD_W-1:0] cfg_y;
    logic [COORD_W-1:0] cfg_w;
    logic [COORD_W-1:0] cfg_h;
    logic [ADDR_W-1:0]  cfg_base;
    logic               cfg_inv;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_q;
    logic               pix_on;
    logic               pix_hit;
    logic [1:0]         pix_win;
    modport master (
        output col_addr_sig, row_addr_sig, cfg_we, cfg_sel, cfg_x, cfg_y, cfg_w, cfg_h,
               cfg_base, cfg_inv, rom_q,
        input  rom_addr, pix_on, pix_hit, pix_win
    );
    modport slave (
        input  col_addr_sig, row_addr_sig, cfg_we, cfg_sel, cfg_x, cfg_y, cfg_w, cfg_h,
               cfg_base, cfg_inv, rom_q,
        output rom_addr, pix_on, pix_hit, pix_win
    );
endinterface

// File: rtl/overlay_rom_sched.sv
// overlay_rom_sched: priority-arbitrated single-port ROM sharing for up to four overlay windows.
// Define OVERLAY_INVERT_EN to store and apply a per-window pixel invert bit.
module overlay_rom_sched #(
    parameter int NUM_WIN = 4,
    parameter int ADDR_W  = 13,
    parameter int COORD_W = 11
) (
    input logic               clk,
    input logic               rst_n,
    overlay_rom_sched_if.slave bus
);
    localparam int C1 = COORD_W + 1;
    logic [COORD_W-1:0] sx [NUM_WIN];
    logic [COORD_W-1:0] sy [NUM_WIN];
    logic [COORD_W-1:0] sw [NUM_WIN];
    logic [COORD_W-1:0] sh [NUM_WIN];
    logic [ADDR_W-1:0]  sb [NUM_WIN];
    logic [COORD_W-1:0] ax [NUM_WIN];
    logic [COORD_W-1:0] ay [NUM_WIN];
    logic [COORD_W-1:0] aw [NUM_WIN];
    logic [COORD_W-1:0] ah [NUM_WIN];
    logic [ADDR_W-1:0]  ab [NUM_WIN];
    logic [COORD_W-1:0] ex [NUM_WIN];
    logic [COORD_W-1:0] ey [NUM_WIN];
    logic [COORD_W-1:0] ew [NUM_WIN];
    logic [COORD_W-1:0] eh [NUM_WIN];
    logic [ADDR_W-1:0]  eb [NUM_WIN];
    logic [ADDR_W-1:0]  rp [NUM_WIN];
    logic [ADDR_W-1:0]  rp_n [NUM_WIN];
    logic [ADDR_W-1:0]  off [NUM_WIN];
    logic [NUM_WIN-1:0] hit, row_in, e_inv;
    logic [COORD_W-1:0] row_q;
    logic               fs, row_chg, inv_s0, hit_d1, hit_d2, inv_d1, inv_d2;
    logic [1:0]         win, win_d1, win_d2;
    logic [ADDR_W-1:0]  addr;
    assign fs      = bus.row_addr_sig == '0 && bus.col_addr_sig == '0;
    assign row_chg = bus.row_addr_sig != row_q;
    // On frame start the shadow set is already the one being drawn, so pixel (0,0) sees it too
    for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
        assign ex[g] = fs ? sx[g] : ax[g];
        assign ey[g] = fs ? sy[g] : ay[g];
        assign ew[g] = fs ? sw[g] : aw[g];
        assign eh[g] = fs ? sh[g] : ah[g];
        assign eb[g] = fs ? sb[g] : ab[g];
        assign row_in[g] = bus.row_addr_sig > ey[g] && C1'(bus.row_addr_sig) < C1'(ey[g]) + C1'(eh[g]);
        assign hit[g] = ew[g] != '0 && eh[g] != '0
                     && bus.col_addr_sig >= ex[g] && C1'(bus.col_addr_sig) < C1'(ex[g]) + C1'(ew[g])
                     && bus.row_addr_sig >= ey[g] && C1'(bus.row_addr_sig) < C1'(ey[g]) + C1'(eh[g]);
        assign rp_n[g] = fs ? sb[g] : !row_chg ? rp[g] : bus.row_addr_sig == ey[g] ? eb[g]
                       : row_in[g] ? rp[g] + ADDR_W'(ew[g]) : rp[g];
        assign off[g] = ADDR_W'(bus.col_addr_sig - ex[g]);
    end
`ifdef OVERLAY_INVERT_EN
    logic [NUM_WIN-1:0] s_inv, a_inv;
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s_inv <= '0;
            a_inv <= '0;
        end else begin
            for (int i = 0; i < NUM_WIN; i++)
                if (bus.cfg_we && bus.cfg_sel == 2'(i)) s_inv[i] <= bus.cfg_inv;
            if (fs) a_inv <= s_inv;
        end
    end
    assign e_inv = fs ? s_inv : a_inv;
`else
    logic unused_inv;
    assign unused_inv = bus.cfg_inv;
    assign e_inv = '0;
`endif
    always_comb begin
        win = '0;
        addr = '0;
        inv_s0 = 1'b0;
        for (int i = NUM_WIN - 1; i >= 0; i--)
            if (hit[i]) begin
                win = 2'(i);
                addr = rp_n[i] + off[i];
                inv_s0 = e_inv[i];
            end
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                sx[i] <= '0; sy[i] <= '0; sw[i] <= '0; sh[i] <= '0; sb[i] <= '0;
                ax[i] <= '0; ay[i] <= '0; aw[i] <= '0; ah[i] <= '0; ab[i] <= '0;
                rp[i] <= '0;
            end
            row_q <= '0;
            bus.rom_addr <= '0;
            {hit_d1, hit_d2, inv_d1, inv_d2} <= '0;
            {win_d1, win_d2} <= '0;
            bus.pix_on <= 1'b0;
            bus.pix_hit <= 1'b0;
            bus.pix_win <= '0;
        end else begin
            row_q <= bus.row_addr_sig;
            for (int i = 0; i < NUM_WIN; i++) begin
                if (bus.cfg_we && bus.cfg_sel == 2'(i)) begin
                    sx[i] <= bus.cfg_x; sy[i] <= bus.cfg_y; sw[i] <= bus.cfg_w;
                    sh[i] <= bus.cfg_h; sb[i] <= bus.cfg_base;
                end
                if (fs) begin
                    ax[i] <= sx[i]; ay[i] <= sy[i]; aw[i] <= sw[i]; ah[i] <= sh[i]; ab[i] <= sb[i];
                end
                rp[i] <= rp_n[i];
            end
            bus.rom_addr <= addr;
            hit_d1 <= |hit;
            win_d1 <= win;
            inv_d1 <= inv_s0;
            hit_d2 <= hit_d1;
            win_d2 <= win_d1;
            inv_d2 <= inv_d1;
            bus.pix_on <= hit_d2 & (bus.rom_q ^ inv_d2);
            bus.pix_hit <= hit_d2;
            bus.pix_win <= win_d2;
        end
    end
endmodule

// File: doc/overlay_rom_sched.md
# overlay_rom_sched

Time-shares one single-port 1-bit image ROM between up to four rectangular overlay windows (next-piece preview, score label, banners) on the VGA scan. Sits between the VGA sync generator's `col_addr_sig`/`row_addr_sig` and the pixel mux. Each cycle it picks the highest-priority window covering the current pixel, generates that window's ROM address without a multiplier, and returns a pipeline-aligned pixel bit with the winning window ID.

## Interface
- `NUM_WIN`, 4: number of windows (1..4). Window 0 has the highest priority.
- `ADDR_W`, 13: ROM address width.
- `COORD_W`, 11: scan-coordinate width.
- `clk`  in  1  pixel clock. Rising-edge only.
- `rst_n`  in  1  asynchronous reset, **active-high** (the `_n` name is kept for codebase consistency). Clears all state.
- `col_addr_sig`  in  COORD_W  current scan column, advances by 1 per clk.
- `row_addr_sig`  in  COORD_W  current scan row.
- `cfg_we`  in  1  shadow-register write strobe.
- `cfg_sel`  in  2  window index to write. Writes with index ≥ NUM_WIN are ignored.
- `cfg_x`, `cfg_y`  in  COORD_W each  window top-left corner.
- `cfg_w`, `cfg_h`  in  COORD_W each  window size. 0 in either disables the window.
- `cfg_base`  in  ADDR_W  ROM address of the image's first pixel.
- `cfg_inv`  in  1  invert the pixel (honoured only when OVERLAY_INVERT_EN is defined).
- `rom_addr`  out  ADDR_W  ROM address, registered.
- `rom_q`  in  1  ROM data, valid 1 clk after `rom_addr`.
- `pix_on`  out  1  overlay pixel value.
- `pix_hit`  out  1  some window covers this pixel.
- `pix_win`  out  2  index of the winning window.

## Operation
- Config path:
  - `cfg_we` writes the shadow set for `cfg_sel`.
  - The active set loads from shadow on the frame-start cycle (`row_addr_sig==0 && col_addr_sig==0`).
  - Mid-frame writes never change the image being drawn.
- Hit test for window i: `x ≤ col < x+w` and `y ≤ row < y+h`, with w≠0 and h≠0. Comparisons are done at COORD_W+1 bits so that x+w cannot wrap.
- Arbitration: fixed priority, lowest index wins. Losing windows get no ROM access that cycle.
- Address for window i: `base + (row−y)*w + (col−x)`, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - Implemented with a per-window row pointer `rp[i]`. No multiplier is allowed.
  - On a row change (`row_addr_sig` differs from its registered value) with row == y: `rp = base`.
  - On a row change with y < row < y+h: `rp += w`.
  - Otherwise `rp` holds.
  - Frame start resets every `rp` to the newly activated base.
  - Rows must advance monotonically by 1. Any other jump gives undefined addresses until the next frame start.
- Address select: `rom_addr <= rp[win] + (col−x[win])` when there is a hit, else 0.
- Pixel output:
  - `pix_on = hit_d2 ? (rom_q ^ inv_d2) : 0`.
  - `pix_hit` and `pix_win` are delayed copies of the stage-0 decision. With no hit, `pix_win = 0`.

## Timing
- Pipeline, with inputs sampled at edge N:
  - edge N: `rom_addr`, hit and win are registered.
  - edge N+1: ROM returns `rom_q`.
  - edge N+2: `pix_on`, `pix_hit` and `pix_win` are registered.
  - Net latency is 3 clk from coordinate to output. The sync path must delay h/v sync to match.
- Reset values: `rom_addr=0`, `pix_on=0`, `pix_hit=0`, `pix_win=0`. All shadow and active windows cleared, so all are disabled. All `rp` = 0.
- Reset asserted mid-frame: outputs drop to 0 asynchronously. Overlays stay blank until after the first frame-start cycle following a config write.
- Simultaneous events:
  - `cfg_we` on the frame-start cycle: the write lands in shadow only and is activated at the next frame start.
  - Frame start coinciding with the window's first row (y=0): `rp` loads the new base on that cycle.
- Overlapping windows: only the winner's pixel appears, even when its pixel is 0. Transparency is not supported.
- Throughput is one pixel per clk, with no stalls.

## Configuration
- `OVERLAY_INVERT_EN` defined: `cfg_inv` is stored per window in shadow and active sets and carried down the pipe. `pix_on` is XORed with it.
- Not defined: no invert storage. `cfg_inv` is ignored and `pix_on = hit ? rom_q : 0`.

## Test plan
- Reset, then scan a full frame with no config → `pix_hit=0` and `pix_on=0` throughout. `rom_addr=0` throughout.
- Window 0: x=100, y=10, w=111, h=43, base=0, written mid-frame → no hit that frame.
  - Next frame at (100,10): `rom_addr=0`, and `pix_hit=1` 3 clk later.
  - At (210,52): `rom_addr=4772`.
  - At (211,52) and (100,53): `pix_hit=0`.
- Windows 0 and 1 overlapping at (120,20) → `pix_win=0` and `rom_addr` from window 0. At (120,20) with window 0 disabled (w=0) after the next frame start → `pix_win=1`.
- ROM model returning a checkerboard, with `OVERLAY_INVERT_EN` defined and inv=1 → `pix_on = ~rom_q` inside the window and 0 outside. Without the macro → `pix_on = rom_q`.
- base=8190, w=4, h=2 → row 0 addresses 8190, 8191, 0, 1 (wrap). Row 1 starts at 2.
- Assert `rst_n` for 1 clk mid-window → outputs go to 0 immediately and stay 0 until reconfiguration plus the next frame start.
